conv_fprop3_acc_stage: RTL and testbench

CONV_FPROP3_ACC_STAGE -- requirements
Module: conv_fprop3_acc_stage

---
 rtl/conv_fprop3_pkg.sv | 17 +
 rtl/conv_fprop3_acc_out_slice.sv | 41 ++++
 rtl/conv_fprop3_acc_stage.sv | 101 ++++++++++
 tb/tb_conv_fprop3_acc_stage.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_fprop3_pkg.sv
// Shared widths, counter type and FSM encoding for the fprop3 accumulate stage.
// Pure declarations: no logic, no latency, no flow control.
package conv_fprop3_pkg;

  localparam int DIN_WIDTH_DEF    = 62;
  localparam int ACC_WIDTH_DEF    = 66;
  localparam int KERNEL_TERMS_DEF = 9;
  localparam int CNT_WIDTH        = 8;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_e;

endpackage

// File: rtl/conv_fprop3_acc_out_slice.sv
// Result register for one window sum; valid 1 cycle after load.
// in_ready drops only while a result is held and out_ready is low; load while draining reloads with no bubble.
module conv_fprop3_acc_out_slice
  import conv_fprop3_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_vld,
  input  logic [ACC_WIDTH-1:0] load_dat,
  input  logic                 load_sat,
  input  logic                 load_err,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_sat,
  output logic                 out_err,
  input  logic                 out_ready
);

  // A held result only blocks upstream when downstream is not taking it this cycle.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_err   <= 1'b0;
    end else if (load_vld) begin
      out_valid <= 1'b1;
      out_data  <= load_dat;
      out_sat   <= load_sat;
      out_err   <= load_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/conv_fprop3_acc_stage.sv
// Sums KERNEL_TERMS unsigned products per window with saturation and length checking.
// Result valid 1 cycle after the final beat; in_ready follows the output slice (stalls only on a held, unaccepted result).
module conv_fprop3_acc_stage
  import conv_fprop3_pkg::*;
#(
  parameter int DIN_WIDTH    = DIN_WIDTH_DEF,
  parameter int ACC_WIDTH    = ACC_WIDTH_DEF,
  parameter int KERNEL_TERMS = KERNEL_TERMS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [DIN_WIDTH-1:0] in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_sat,
  output logic                 out_err,
  input  logic                 out_ready
);

  localparam int   SUM_W    = ACC_WIDTH + 1;
  localparam cnt_t LAST_IDX = cnt_t'(KERNEL_TERMS - 1);

  acc_state_e           state_q, state_d;
  cnt_t                 cnt_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic                 sat_q;

  logic                 beat_acc;
  logic                 at_term;
  logic                 beat_final;
  logic [ACC_WIDTH-1:0] acc_base;
  logic [SUM_W-1:0]     sum_full;
  logic                 sum_ovf;
  logic [ACC_WIDTH-1:0] sum_clip;
  logic                 win_sat;
  logic                 win_err;

  assign beat_acc   = in_valid && in_ready;
  assign at_term    = (cnt_q == LAST_IDX);
  assign beat_final = in_last || at_term;

  // One extra bit catches the carry out; once saturated the clipped value keeps overflowing back to all-ones.
  assign acc_base = (state_q == ST_ACCUM) ? acc_q : '0;
  assign sum_full = {1'b0, acc_base} + SUM_W'(in_data);
  assign sum_ovf  = sum_full[ACC_WIDTH];
  assign sum_clip = sum_ovf ? '1 : sum_full[ACC_WIDTH-1:0];
  assign win_sat  = sat_q || sum_ovf;

  // Early in_last and a missing in_last on the closing term are both length errors.
  assign win_err  = (in_last != at_term);

  always_comb begin
    state_d = state_q;
    if (beat_acc) begin
      state_d = beat_final ? ST_IDLE : ST_ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (beat_acc) begin
        if (beat_final) begin
          cnt_q <= '0;
          acc_q <= '0;
          sat_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q + cnt_t'(1);
          acc_q <= sum_clip;
          sat_q <= win_sat;
        end
      end
    end
  end

  conv_fprop3_acc_out_slice #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_out_slice (
    .clk       (clk),
    .reset     (reset),
    .load_vld  (beat_acc && beat_final),
    .load_dat  (sum_clip),
    .load_sat  (win_sat),
    .load_err  (win_err),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_err   (out_err),
    .out_ready (out_ready)
  );

endmodule

// File: tb/tb_conv_fprop3_acc_stage.sv
// Bench for conv_fprop3_acc_stage: default instance against a window-sum model, plus a 3-term/63-bit instance for saturation.
module tb_conv_fprop3_acc_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        iv0, il0, ordy0, irdy0, ov0, os0, oe0;
  logic [61:0] idat0;
  logic [65:0] od0;
  logic        iv1, il1, ordy1, irdy1, ov1, os1, oe1;
  logic [61:0] idat1;
  logic [62:0] od1;

  conv_fprop3_acc_stage dut (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_data(idat0), .in_last(il0),
    .in_ready(irdy0), .out_valid(ov0), .out_data(od0), .out_sat(os0), .out_err(oe0),
    .out_ready(ordy0)
  );

  conv_fprop3_acc_stage #(.DIN_WIDTH(62), .ACC_WIDTH(63), .KERNEL_TERMS(3)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_data(idat1), .in_last(il1),
    .in_ready(irdy1), .out_valid(ov1), .out_data(od1), .out_sat(os1), .out_err(oe1),
    .out_ready(ordy1)
  );

  typedef struct {
    logic [65:0] d;
    logic        s;
    logic        e;
    int          c;
  } res_t;

  res_t        exp0[$];
  res_t        got0[$];
  res_t        got1[$];
  logic [61:0] win0[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          chk_cyc = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset === 1'b1 && ov0 === 1'b1 && ordy0 === 1'b1)
      got0.push_back('{d: od0, s: os0, e: oe0, c: cyc});
    if (reset === 1'b1 && ov1 === 1'b1 && ordy1 === 1'b1)
      got1.push_back('{d: {3'b000, od1}, s: os1, e: oe1, c: cyc});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  // Present one beat to the default instance; window model: sum the beats, clip to 66 bits,
  // error unless exactly 9 beats with in_last on the 9th.
  task automatic put_beat(input logic [61:0] d, input logic l, input bit rnd, output int waits);
    logic [127:0] sum;
    res_t         r;
    iv0 = 1'b1; idat0 = d; il0 = l; waits = 0;
    if (rnd) ordy0 = 1'($urandom_range(0, 1));
    #1;
    while (irdy0 !== 1'b1 && waits < 64) begin
      @(posedge clk); #1;
      if (rnd) ordy0 = 1'($urandom_range(0, 1));
      #1;
      waits++;
    end
    checks++;
    if (irdy0 !== 1'b1) begin
      errors++;
      $display("FAIL beat_accept: in_ready=%b after %0d cycles, required 1", irdy0, waits);
      iv0 = 1'b0;
    end else begin
      @(posedge clk); #1;
      iv0 = 1'b0; idat0 = {$urandom(), $urandom()}; il0 = 1'($urandom_range(0, 1));
      win0.push_back(d);
      if (l || win0.size() == 9) begin
        sum = '0;
        foreach (win0[i]) sum += 128'(win0[i]);
        r.s = (sum > {62'd0, {66{1'b1}}});
        r.d = r.s ? {66{1'b1}} : sum[65:0];
        r.e = !(l && win0.size() == 9);
        r.c = chk_cyc ? cyc : -1;
        exp0.push_back(r);
        win0.delete();
      end
    end
  endtask

  task automatic put_beat1(input logic [61:0] d, input logic l);
    int waits = 0;
    iv1 = 1'b1; idat1 = d; il1 = l;
    #1;
    while (irdy1 !== 1'b1 && waits < 64) begin
      @(posedge clk); #2; waits++;
    end
    checks++;
    if (irdy1 !== 1'b1) begin
      errors++;
      $display("FAIL sat_beat_accept: in_ready=%b, required 1", irdy1);
    end else begin
      @(posedge clk); #1;
    end
    iv1 = 1'b0; il1 = 1'b0;
  endtask

  task automatic drain();
    ordy0 = 1'b1; ordy1 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (irdy0 !== 1'b1 || ov0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1 0", irdy0, ov0);
    end
    checks++;
    if (od0 !== '0 || os0 !== 1'b0 || oe0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: data=%h sat=%b err=%b, required 0 0 0", od0, os0, oe0);
    end
    checks++;
    if (irdy1 !== 1'b1 || ov1 !== 1'b0 || od1 !== '0) begin
      errors++;
      $display("FAIL reset_sat_inst: in_ready=%b out_valid=%b data=%h, required 1 0 0", irdy1, ov1, od1);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (irdy0 !== 1'b1 || ov0 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: in_ready=%b out_valid=%b, required 1 0", irdy0, ov0);
    end
  endtask

  task automatic test_basic();
    int w;
    chk_cyc = 1'b1; ordy0 = 1'b1;
    for (int v = 1; v <= 9; v++) put_beat(62'(v), v == 9, 1'b0, w);
    drain();
    checks++;
    if (got0.size() != exp0.size()) begin
      errors++;
      $display("FAIL basic_count: got %0d results, required %0d", got0.size(), exp0.size());
    end
    for (int i = 0; i < got0.size() && i < exp0.size(); i++) begin
      checks++;
      if (got0[i].d !== exp0[i].d || got0[i].s !== exp0[i].s || got0[i].e !== exp0[i].e ||
          (exp0[i].c >= 0 && got0[i].c !== exp0[i].c)) begin
        errors++;
        $display("FAIL basic_result[%0d]: data=%h sat=%b err=%b cyc=%0d, required %h %b %b %0d",
                 i, got0[i].d, got0[i].s, got0[i].e, got0[i].c, exp0[i].d, exp0[i].s, exp0[i].e, exp0[i].c);
      end
    end
    checks++;
    if (got0.size() < 1 || got0[0].d !== 66'd45 || got0[0].s !== 1'b0 || got0[0].e !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum45: results=%0d, required one result of 45 with sat=0 err=0", got0.size());
    end
    got0.delete(); exp0.delete();
  endtask

  task automatic test_saturation();
    logic [61:0] big;
    logic [62:0] max63;
    big = '1; max63 = '1;
    ordy1 = 1'b1;
    put_beat1(big, 1'b0); put_beat1(big, 1'b0); put_beat1(big, 1'b1);
    put_beat1(62'd1, 1'b0); put_beat1(62'd2, 1'b0); put_beat1(62'd3, 1'b1);
    drain();
    checks++;
    if (got1.size() != 2) begin
      errors++;
      $display("FAIL sat_count: got %0d results, required 2", got1.size());
    end
    checks++;
    if (got1.size() < 1 || got1[0].d !== {3'b000, max63} || got1[0].s !== 1'b1 || got1[0].e !== 1'b0) begin
      errors++;
      $display("FAIL sat_clip: data=%h sat=%b err=%b, required %h 1 0",
               got1.size() > 0 ? got1[0].d : 66'd0, got1.size() > 0 ? got1[0].s : 1'b0,
               got1.size() > 0 ? got1[0].e : 1'b0, max63);
    end
    checks++;
    if (got1.size() < 2 || got1[1].d !== 66'd6 || got1[1].s !== 1'b0 || got1[1].e !== 1'b0) begin
      errors++;
      $display("FAIL sat_cleared: second window data=%h sat=%b, required 6 0",
               got1.size() > 1 ? got1[1].d : 66'd0, got1.size() > 1 ? got1[1].s : 1'b0);
    end
    got1.delete();
  endtask

  task automatic test_backpressure();
    int w;
    chk_cyc = 1'b0; ordy0 = 1'b0;
    for (int b = 1; b <= 9; b++) put_beat({$urandom(), $urandom()}, b == 9, 1'b0, w);
    iv0 = 1'b1; idat0 = 62'd2; il0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (irdy0 !== 1'b0 || ov0 !== 1'b1 || exp0.size() < 1 || od0 !== exp0[0].d) begin
        errors++;
        $display("FAIL stall[%0d]: in_ready=%b out_valid=%b data=%h, required 0 1 %h",
                 k, irdy0, ov0, od0, exp0.size() > 0 ? exp0[0].d : 66'd0);
      end
      @(posedge clk); #1;
    end
    iv0 = 1'b0; il0 = 1'b0;
    ordy0 = 1'b1; chk_cyc = 1'b1;
    for (int b = 1; b <= 9; b++) put_beat(62'd2, b == 9, 1'b0, w);
    drain();
    checks++;
    if (got0.size() != exp0.size()) begin
      errors++;
      $display("FAIL bp_count: got %0d results, required %0d", got0.size(), exp0.size());
    end
    for (int i = 0; i < got0.size() && i < exp0.size(); i++) begin
      checks++;
      if (got0[i].d !== exp0[i].d || got0[i].s !== exp0[i].s || got0[i].e !== exp0[i].e ||
          (exp0[i].c >= 0 && got0[i].c !== exp0[i].c)) begin
        errors++;
        $display("FAIL bp_result[%0d]: data=%h sat=%b err=%b cyc=%0d, required %h %b %b %0d",
                 i, got0[i].d, got0[i].s, got0[i].e, got0[i].c, exp0[i].d, exp0[i].s, exp0[i].e, exp0[i].c);
      end
    end
    checks++;
    if (got0.size() != 2 || got0[1].d !== 66'd18 || got0[1].e !== 1'b0) begin
      errors++;
      $display("FAIL bp_sum18: results=%0d, required 2 with the second equal to 18 err=0", got0.size());
    end
    got0.delete(); exp0.delete();
  endtask

  task automatic test_mismatch();
    int w;
    chk_cyc = 1'b1; ordy0 = 1'b1;
    for (int b = 1; b <= 4; b++) put_beat(62'(10 * b), b == 4, 1'b0, w);
    for (int b = 1; b <= 9; b++) put_beat(62'($urandom()), 1'b0, 1'b0, w);
    drain();
    checks++;
    if (got0.size() != exp0.size()) begin
      errors++;
      $display("FAIL mm_count: got %0d results, required %0d", got0.size(), exp0.size());
    end
    for (int i = 0; i < got0.size() && i < exp0.size(); i++) begin
      checks++;
      if (got0[i].d !== exp0[i].d || got0[i].s !== exp0[i].s || got0[i].e !== exp0[i].e ||
          (exp0[i].c >= 0 && got0[i].c !== exp0[i].c)) begin
        errors++;
        $display("FAIL mm_result[%0d]: data=%h sat=%b err=%b cyc=%0d, required %h %b %b %0d",
                 i, got0[i].d, got0[i].s, got0[i].e, got0[i].c, exp0[i].d, exp0[i].s, exp0[i].e, exp0[i].c);
      end
    end
    checks++;
    if (got0.size() != 2 || got0[0].d !== 66'd100 || got0[0].e !== 1'b1 || got0[1].e !== 1'b1) begin
      errors++;
      $display("FAIL mm_flags: results=%0d, required 2 (100 with err=1, then err=1)", got0.size());
    end
    got0.delete(); exp0.delete();
  endtask

  task automatic test_reset_mid();
    int w;
    chk_cyc = 1'b1; ordy0 = 1'b1;
    for (int b = 1; b <= 5; b++) put_beat(62'd7, 1'b0, 1'b0, w);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    win0.delete();
    checks++;
    if (ov0 !== 1'b0 || irdy0 !== 1'b1 || od0 !== '0) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b data=%h, required 0 1 0", ov0, irdy0, od0);
    end
    for (int b = 1; b <= 9; b++) put_beat(62'd1, b == 9, 1'b0, w);
    drain();
    checks++;
    if (got0.size() != 1 || got0[0].d !== 66'd9 || got0[0].e !== 1'b0 || exp0.size() != 1 ||
        got0[0].c !== exp0[0].c) begin
      errors++;
      $display("FAIL mid_reset_sum: results=%0d first=%h, required one result of 9",
               got0.size(), got0.size() > 0 ? got0[0].d : 66'd0);
    end
    got0.delete(); exp0.delete();
  endtask

  task automatic test_back_to_back();
    int w;
    chk_cyc = 1'b1; ordy0 = 1'b1;
    for (int n = 0; n < 4; n++) begin
      for (int b = 1; b <= 9; b++) begin
        put_beat(62'd5, b == 9, 1'b0, w);
        checks++;
        if (w != 0) begin
          errors++;
          $display("FAIL stream_ready: window %0d beat %0d waited %0d cycles, required 0", n, b, w);
        end
      end
    end
    drain();
    checks++;
    if (got0.size() != 4 || exp0.size() != 4) begin
      errors++;
      $display("FAIL stream_count: got %0d results, required 4", got0.size());
    end
    for (int i = 0; i < got0.size() && i < exp0.size(); i++) begin
      checks++;
      if (got0[i].d !== 66'd45 || got0[i].e !== 1'b0 || got0[i].c !== exp0[i].c) begin
        errors++;
        $display("FAIL stream_result[%0d]: data=%h err=%b cyc=%0d, required 45 0 %0d",
                 i, got0[i].d, got0[i].e, got0[i].c, exp0[i].c);
      end
    end
    got0.delete(); exp0.delete();
  endtask

  task automatic test_random();
    int          w, len;
    logic [63:0] r64;
    logic        l;
    chk_cyc = 1'b0;
    for (int n = 0; n < 30; n++) begin
      len = $urandom_range(1, 9);
      for (int b = 1; b <= len; b++) begin
        l = (b == len) ? ((len < 9) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
        r64 = {$urandom(), $urandom()};
        put_beat(r64[61:0], l, 1'b1, w);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
      end
    end
    drain();
    checks++;
    if (got0.size() != exp0.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d results, required %0d", got0.size(), exp0.size());
    end
    for (int i = 0; i < got0.size() && i < exp0.size(); i++) begin
      checks++;
      if (got0[i].d !== exp0[i].d || got0[i].s !== exp0[i].s || got0[i].e !== exp0[i].e) begin
        errors++;
        $display("FAIL rand_result[%0d]: data=%h sat=%b err=%b, required %h %b %b",
                 i, got0[i].d, got0[i].s, got0[i].e, exp0[i].d, exp0[i].s, exp0[i].e);
      end
    end
    got0.delete(); exp0.delete();
  endtask

  initial begin
    reset = 1'b0;
    iv0 = 1'b0; il0 = 1'b0; idat0 = '0; ordy0 = 1'b1;
    iv1 = 1'b0; il1 = 1'b0; idat1 = '0; ordy1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_mismatch();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
